// File: rtl/imem_loader_if.sv
// Host-side word stream, memory write bus and status for imem_loader.
// ADDR_W must match the ADDR_W of the imem_loader it connects to.
interface imem_loader_if #(
  parameter int ADDR_W = 10
);
  logic              START;
  logic [31:0]       WORD_IN;
  logic              WORD_VALID;
  logic              WORD_LAST;
  logic              WORD_READY;
  logic              MEM_WE;
  logic [ADDR_W-1:0] MEM_ADDR;
  logic [7:0]        MEM_WDATA;
  logic              CORE_HOLD;
  logic              BUSY;
  logic              DONE;
  logic              ERR;
  logic [ADDR_W-2:0] WORD_COUNT;
  logic [31:0]       CHECKSUM;

  modport master (
    output START, WORD_IN, WORD_VALID, WORD_LAST,
    input  WORD_READY, MEM_WE, MEM_ADDR, MEM_WDATA, CORE_HOLD, BUSY, DONE, ERR,
           WORD_COUNT, CHECKSUM
  );

  modport slave (
    input  START, WORD_IN, WORD_VALID, WORD_LAST,
    output WORD_READY, MEM_WE, MEM_ADDR, MEM_WDATA, CORE_HOLD, BUSY, DONE, ERR,
           WORD_COUNT, CHECKSUM
  );
endinterface

// File: rtl/imem_loader.sv
// Streams 32-bit program words into byte-wide instruction memory, big-endian, 1 accept + 4 write cycles per word;
// WORD_READY drops for the 4 write cycles. Optional running word sum under IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0,
  parameter int MAX_WORDS = 256
) (
  input  logic          CLK,
  input  logic          RESET_N,
  imem_loader_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCEPT,
    S_WRITE,
    S_FINISH,
    S_ERROR
  } state_t;

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-2:0] CAP  = (ADDR_W-1)'(MAX_WORDS);

  state_t            state;
  logic [1:0]        idx;
  logic [31:0]       shreg;
  logic              last_q;
  logic              ready_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        wdata_q;
  logic              hold_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;
  logic [ADDR_W-2:0] count_q;
  logic [ADDR_W-2:0] count_nxt;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0]       csum_q;
`endif

  assign count_nxt = count_q + 1'b1;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state   <= S_IDLE;
      idx     <= 2'd0;
      shreg   <= '0;
      last_q  <= 1'b0;
      ready_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      hold_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      count_q <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE, S_ERROR: begin
          if (bus.START) begin
            state   <= S_ACCEPT;
            count_q <= '0;
            err_q   <= 1'b0;
            hold_q  <= 1'b1;
            busy_q  <= 1'b1;
            ready_q <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q  <= '0;
`endif
          end
        end
        S_ACCEPT: begin
          if (bus.WORD_VALID && ready_q) begin
            // First byte goes out on the next cycle; the rest shift out of shreg.
            shreg   <= {bus.WORD_IN[23:0], 8'h00};
            last_q  <= bus.WORD_LAST;
            ready_q <= 1'b0;
            we_q    <= 1'b1;
            addr_q  <= BASE + ADDR_W'({count_q, 2'b00});
            wdata_q <= bus.WORD_IN[31:24];
            idx     <= 2'd0;
            state   <= S_WRITE;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q  <= csum_q + bus.WORD_IN;
`endif
          end
        end
        S_WRITE: begin
          if (idx != 2'd3) begin
            idx     <= idx + 2'd1;
            addr_q  <= addr_q + 1'b1;
            wdata_q <= shreg[31:24];
            shreg   <= {shreg[23:0], 8'h00};
          end else begin
            we_q    <= 1'b0;
            count_q <= count_nxt;
            if (last_q) begin
              state  <= S_FINISH;
              done_q <= 1'b1;
              hold_q <= 1'b0;
              busy_q <= 1'b0;
            end else if (count_nxt == CAP) begin
              // Capacity reached without LAST: stop before any out-of-range write.
              state  <= S_ERROR;
              err_q  <= 1'b1;
              busy_q <= 1'b0;
            end else begin
              state   <= S_ACCEPT;
              ready_q <= 1'b1;
            end
          end
        end
        S_FINISH: state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

  assign bus.WORD_READY = ready_q;
  assign bus.MEM_WE     = we_q;
  assign bus.MEM_ADDR   = addr_q;
  assign bus.MEM_WDATA  = wdata_q;
  assign bus.CORE_HOLD  = hold_q;
  assign bus.BUSY       = busy_q;
  assign bus.DONE       = done_q;
  assign bus.ERR        = err_q;
  assign bus.WORD_COUNT = count_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
  assign bus.CHECKSUM   = csum_q;
`else
  assign bus.CHECKSUM   = 32'h0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Directed plus randomized loads of imem_loader, checked against a word-level memory/status model.
module tb_imem_loader;
  localparam int AW   = 10;
  localparam int MAXW = 4;

  logic CLK = 1'b0;
  logic RESET_N;
  always #5 CLK = ~CLK;

  imem_loader_if #(.ADDR_W(AW)) bus ();

  imem_loader #(.ADDR_W(AW), .BASE_ADDR(0), .MAX_WORDS(MAXW)) dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  // Monitor: every byte the memory would see, in order, plus DONE pulses.
  int             wr_total = 0;
  int             done_total = 0;
  logic [AW+7:0]  wr_log [0:4095];
  always @(posedge CLK) begin
    if (bus.MEM_WE) begin
      wr_log[wr_total % 4096] <= {bus.MEM_ADDR, bus.MEM_WDATA};
      wr_total <= wr_total + 1;
    end
    if (bus.DONE) done_total <= done_total + 1;
  end

  logic [31:0] words [0:7];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"}, bus.WORD_READY, 0);
    chk({tag, "_we"},    bus.MEM_WE, 0);
    chk({tag, "_addr"},  bus.MEM_ADDR, 0);
    chk({tag, "_wdata"}, bus.MEM_WDATA, 0);
    chk({tag, "_hold"},  bus.CORE_HOLD, 0);
    chk({tag, "_busy"},  bus.BUSY, 0);
    chk({tag, "_done"},  bus.DONE, 0);
    chk({tag, "_err"},   bus.ERR, 0);
    chk({tag, "_count"}, bus.WORD_COUNT, 0);
    chk({tag, "_csum"},  bus.CHECKSUM, 0);
  endtask

  // Wait for READY, idle VALID for 'gap' cycles, then offer one word.
  task automatic send_word(input logic [31:0] w, input bit last, input int gap, output bit ok);
    int n;
    ok = 1'b0;
    n = 0;
    while (!bus.WORD_READY && n < 20) begin
      tick();
      n++;
    end
    chk("ready_before_word", bus.WORD_READY, 1);
    for (int g = 0; g < gap; g++) begin
      tick();
      chk("ready_in_gap", bus.WORD_READY, 1);
      chk("no_we_in_gap", bus.MEM_WE, 0);
    end
    bus.WORD_IN    = w;
    bus.WORD_LAST  = last;
    bus.WORD_VALID = 1'b1;
    if (bus.WORD_READY) ok = 1'b1;
    tick();
    bus.WORD_VALID = 1'b0;
    bus.WORD_IN    = $urandom;
    bus.WORD_LAST  = 1'($urandom);
    if (ok) begin
      chk("we_after_accept", bus.MEM_WE, 1);
      chk("ready_low_in_write", bus.WORD_READY, 0);
    end
  endtask

  // One complete load of words[0..n-1]; LAST on word n-1 when with_last.
  task automatic do_load(input int n, input bit with_last, input int gap, input bit glitch);
    int          s_wr, s_done, acc, k;
    bit          fin, ok;
    logic [31:0] sum;
    logic [7:0]  wb;
    logic [AW+7:0] e;
    fin = with_last && (n <= MAXW);
    acc = fin ? n : MAXW;
    sum = 32'h0;
    for (int i = 0; i < acc; i++) sum = sum + words[i];
    s_wr   = wr_total;
    s_done = done_total;

    bus.START = 1'b1;
    tick();
    bus.START = 1'b0;
    chk("start_ready", bus.WORD_READY, 1);
    chk("start_hold",  bus.CORE_HOLD, 1);
    chk("start_busy",  bus.BUSY, 1);
    chk("start_err",   bus.ERR, 0);
    chk("start_count", bus.WORD_COUNT, 0);
    chk("start_csum",  bus.CHECKSUM, 0);

    for (int i = 0; i < acc; i++) begin
      send_word(words[i], with_last && (i == n - 1), gap, ok);
      chk("word_accepted", ok, 1);
      if (glitch && i == 0) begin
        bus.START = 1'b1;
        tick();
        bus.START = 1'b0;
        chk("start_in_write_count", bus.WORD_COUNT, 0);
        chk("start_in_write_we", bus.MEM_WE, 1);
      end
    end

    if (fin) begin
      k = 0;
      while (!bus.DONE && k < 20) begin
        tick();
        k++;
      end
      chk("done_seen",  bus.DONE, 1);
      chk("done_hold",  bus.CORE_HOLD, 0);
      chk("done_busy",  bus.BUSY, 0);
      chk("done_count", bus.WORD_COUNT, n);
      tick();
      chk("done_one_cycle", bus.DONE, 0);
    end else begin
      chk("err_not_early", bus.ERR, 0);
      k = 0;
      while (!bus.ERR && k < 20) begin
        tick();
        k++;
      end
      chk("ovf_err",   bus.ERR, 1);
      chk("ovf_hold",  bus.CORE_HOLD, 1);
      chk("ovf_ready", bus.WORD_READY, 0);
      chk("ovf_count", bus.WORD_COUNT, MAXW);
      bus.WORD_IN    = words[acc];
      bus.WORD_VALID = 1'b1;
      for (int c = 0; c < 8; c++) begin
        tick();
        chk("ovf_ready_held", bus.WORD_READY, 0);
        chk("ovf_no_we", bus.MEM_WE, 0);
      end
      bus.WORD_VALID = 1'b0;
      chk("ovf_err_sticky", bus.ERR, 1);
    end

    chk("we_cycles",   wr_total - s_wr, 4 * acc);
    chk("done_pulses", done_total - s_done, fin);
`ifdef IMEM_LOADER_CHECKSUM_EN
    chk("checksum", bus.CHECKSUM, sum);
`else
    chk("checksum", bus.CHECKSUM, 0);
`endif
    for (int i = 0; i < acc; i++) begin
      for (int j = 0; j < 4; j++) begin
        wb = words[i][31 - 8 * j -: 8];
        e  = {AW'(4 * i + j), wb};
        chk("mem_byte", wr_log[(s_wr + 4 * i + j) % 4096], e);
      end
    end
  endtask

  initial begin
    int  s;
    bit  ok;
    bus.START      = 1'b0;
    bus.WORD_IN    = 32'h0;
    bus.WORD_VALID = 1'b0;
    bus.WORD_LAST  = 1'b0;
    RESET_N        = 1'b0;
    tick();
    tick();
    chk_all_zero("reset");
    RESET_N = 1'b1;
    tick();
    chk_all_zero("idle");

    // Three-word program.
    words[0] = 32'h0001_1020;
    words[1] = 32'h0064_2824;
    words[2] = 32'h0127_4025;
    do_load(3, 1'b1, 0, 1'b0);

    // Backpressure: VALID idle for 3 cycles before each word.
    for (int i = 0; i < 4; i++) words[i] = $urandom;
    do_load(4, 1'b1, 3, 1'b0);

    // Overflow, then a clean reload from address 0.
    for (int i = 0; i < 5; i++) words[i] = $urandom;
    do_load(5, 1'b0, 1, 1'b0);
    for (int i = 0; i < 2; i++) words[i] = $urandom;
    do_load(2, 1'b1, 0, 1'b0);

    // START during WRITE is ignored.
    for (int i = 0; i < 3; i++) words[i] = $urandom;
    do_load(3, 1'b1, 1, 1'b1);

    // Checksum wraps modulo 2^32.
    words[0] = 32'h0000_0001;
    words[1] = 32'h0000_0002;
    words[2] = 32'hFFFF_FFFF;
    do_load(3, 1'b1, 0, 1'b0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    chk("checksum_wrap", bus.CHECKSUM, 32'h0000_0002);
`else
    chk("checksum_wrap", bus.CHECKSUM, 32'h0);
`endif

    // Asynchronous reset while byte 2 of a word is on the bus.
    bus.START = 1'b1;
    tick();
    bus.START = 1'b0;
    send_word(32'hA5C3_5A3C, 1'b1, 0, ok);
    chk("rst_word_accepted", ok, 1);
    tick();
    tick();
    chk("pre_reset_we", bus.MEM_WE, 1);
    chk("pre_reset_addr", bus.MEM_ADDR, 2);
    chk("pre_reset_data", bus.MEM_WDATA, 8'h5A);
    s = wr_total;
    RESET_N = 1'b0;
    #1;
    chk_all_zero("async_rst");
    @(negedge CLK);
    RESET_N = 1'b1;
    for (int c = 0; c < 10; c++) tick();
    chk("post_rst_no_writes", wr_total - s, 0);
    chk("post_rst_we", bus.MEM_WE, 0);
    chk("post_rst_ready", bus.WORD_READY, 0);
    chk("post_rst_hold", bus.CORE_HOLD, 0);
    chk("post_rst_busy", bus.BUSY, 0);

    // Randomized loads.
    for (int r = 0; r < 8; r++) begin
      int n;
      n = $urandom_range(MAXW, 1);
      for (int i = 0; i < 8; i++) words[i] = $urandom;
      do_load(n, 1'b1, $urandom_range(2, 0), 1'($urandom_range(1, 0)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
